row_light_ctrl: RTL
===================

ROW_LIGHT_CTRL -- requirements
Module: row_light_ctrl

Interface
REQ-001 SHALL have parameter N_CELLS, default 8, number of light cells in the row (range 2..16).
REQ-002 SHALL have parameter TICK_DIV, default 50_000_000, clock cycles per row shift (>=2).
REQ-003 SHALL have parameter MAX_MISS, default 5, miss count that ends a game (1..15).
REQ-004 SHALL have port clock  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle pulse, begins a game.
REQ-007 SHALL have port key  input  1  single-cycle catch pulse, already debounced and edge-detected upstream.
REQ-008 SHALL have port lights  output  2*N_CELLS  cell i at bits [2i+1:2i]; 2'b10 green, 2'b01 red, 2'b00 off; cell 0 is the catch cell.
REQ-009 SHALL have port score  output  8  caught-green count.
REQ-010 SHALL have port misses  output  4  miss count.
REQ-011 SHALL have port game_over  output  1  high while in OVER.

Function
REQ-012 SHALL implement FSM IDLE, RUN, OVER; IDLE->RUN and OVER->RUN on start; RUN->OVER when misses reaches MAX_MISS; start in RUN is ignored.
REQ-013 Entering RUN SHALL clear lights, score, misses and tick counter in the same edge.
REQ-014 Tick counter SHALL count 0..TICK_DIV-1 in RUN only and wrap; tick asserts on the cycle it equals TICK_DIV-1.
REQ-015 On tick, cell i SHALL take cell i+1 for i<N_CELLS-1, and cell N_CELLS-1 SHALL take the spawn value.
REQ-016 Spawn value SHALL come from lfsr[1:0]: 2'b11 green, 2'b10 red, otherwise off.
REQ-017 LFSR SHALL be 8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5, advance every cycle in all states, never reach zero.
REQ-018 On tick, a green cell 0 shifted out uncaught SHALL increment misses; red or off shifted out SHALL have no effect.
REQ-019 Key in RUN with cell 0 green SHALL increment score and clear cell 0; with cell 0 red SHALL increment misses and clear cell 0; with cell 0 off SHALL have no effect.
REQ-020 Key and tick in the same cycle SHALL resolve key against pre-shift cell 0 first, then shift; the consumed cell SHALL NOT also count as a shift-out miss.
REQ-021 Key and tick each causing a miss in one cycle is impossible per REQ-020; at most one miss increment per cycle.
REQ-022 score SHALL saturate at 255; misses SHALL saturate at MAX_MISS.
REQ-023 Entering OVER SHALL clear lights; score and misses SHALL hold until next start.
REQ-024 key in IDLE or OVER SHALL be ignored.
REQ-025 All outputs SHALL be registered; lights/score/misses update one edge after the causing event.

Reset
REQ-026 reset low SHALL immediately force IDLE, lights 0, score 0, misses 0, game_over 0, tick counter 0, LFSR 8'hA5, regardless of state or pending key/tick.
REQ-027 Release SHALL take effect on the next rising clock edge with no spurious tick or key action.

Configuration
REQ-028 Macro ROW_LIGHT_PAUSE_EN defined SHALL add input pause (1 bit): while high in RUN, tick counter, shifts and key actions freeze, LFSR still advances, lights hold.
REQ-029 Without ROW_LIGHT_PAUSE_EN SHALL have no pause port and behave as never paused.

Verification (N_CELLS=4, TICK_DIV=4, MAX_MISS=3)
REQ-030 reset low mid-RUN with lights nonzero -> lights 0, score 0, misses 0, game_over 0 without clock edge.
REQ-031 start, force lights 8'b00_00_00_10 via run, key while cell0 green -> score 1, cell0 00, misses 0.
REQ-032 key while cell0 red -> misses 1, cell0 00, score unchanged.
REQ-033 green in cell0 at tick, key same cycle -> score +1, misses unchanged, cell0 takes old cell1.
REQ-034 three uncaught greens shifted out -> misses 3, game_over 1, lights 0; next start -> RUN, score 0, misses 0.
REQ-035 with ROW_LIGHT_PAUSE_EN, pause high 10 cycles in RUN -> lights and tick counter unchanged; key ignored.

Source files
------------

// File: rtl/row_light_ctrl.sv
// row_light_ctrl: row-of-lights catch game; lights shift toward cell 0 every TICK_DIV cycles, key catches greens.
// Optional build macro ROW_LIGHT_PAUSE_EN adds a pause input that freezes play while held in RUN.
module row_light_ctrl #(
   parameter int N_CELLS  = 8,
   parameter int TICK_DIV = 50_000_000,
   parameter int MAX_MISS = 5
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   key,
`ifdef ROW_LIGHT_PAUSE_EN
   input  logic                   pause,
`endif
   output logic [2*N_CELLS-1:0]   lights,
   output logic [7:0]             score,
   output logic [3:0]             misses,
   output logic                   game_over
);
   localparam int TW = $clog2(TICK_DIV);
   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
   state_t state;
   logic [TW-1:0] tick_cnt;
   logic [7:0] lfsr;
   logic paused, active, tick, key_act, score_inc, miss_inc;
   logic [1:0] spawn;
   logic [2*N_CELLS-1:0] keyed, shifted;
   logic [3:0] miss_nxt;
`ifdef ROW_LIGHT_PAUSE_EN
   assign paused = pause;
`else
   assign paused = 1'b0;
`endif
   // key resolves against pre-shift cell 0, then the shift sees the cleared cell so a catch is never also a miss
   always_comb begin
      active    = state == RUN && !paused;
      tick      = active && tick_cnt == TW'(TICK_DIV - 1);
      key_act   = active && key && lights[1:0] != 2'b00;
      score_inc = key_act && lights[1:0] == 2'b10;
      keyed     = key_act ? {lights[2*N_CELLS-1:2], 2'b00} : lights;
      spawn     = lfsr[1:0] == 2'b11 ? 2'b10 : lfsr[1:0] == 2'b10 ? 2'b01 : 2'b00;
      shifted   = tick ? {spawn, keyed[2*N_CELLS-1:2]} : keyed;
      miss_inc  = (key_act && lights[1:0] == 2'b01) || (tick && keyed[1:0] == 2'b10);
      miss_nxt  = miss_inc && misses != 4'(MAX_MISS) ? misses + 4'd1 : misses;
   end
   // game FSM with registered outputs; LFSR free-runs in every state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         lights    <= '0;
         score     <= '0;
         misses    <= '0;
         game_over <= 1'b0;
         tick_cnt  <= '0;
         lfsr      <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         if (state != RUN) begin
            if (start) begin
               state     <= RUN;
               lights    <= '0;
               score     <= '0;
               misses    <= '0;
               game_over <= 1'b0;
               tick_cnt  <= '0;
            end
         end else if (active) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            score    <= score_inc && score != 8'hFF ? score + 8'd1 : score;
            misses   <= miss_nxt;
            if (miss_nxt == 4'(MAX_MISS)) begin
               state     <= OVER;
               lights    <= '0;
               game_over <= 1'b1;
            end else begin
               lights <= shifted;
            end
         end
      end
   end
endmodule
